mul_req_arbiter: RTL

//  Shares one sequential Booth multiplier (start/done, 8x8 signed -> 16-bit product) between two requesters.

---
 rtl/mul_req_arbiter_if.sv | 57 +++++
 rtl/mul_req_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mul_req_arbiter_if.sv
// Bundle of handshake and datapath signals around mul_req_arbiter.
//   slave  : the arbiter's view (takes requests, drives the multiplier and responses)
//   master : the environment's view (requesters, multiplier, response consumer)
// Signals
//   req0_valid/req0_a/req0_b/req0_ready : requester 0 valid/ready request channel
//   req1_valid/req1_a/req1_b/req1_ready : requester 1 valid/ready request channel
//   mul_start/mul_a/mul_b/mul_clr       : command side of the sequential multiplier
//   mul_done/mul_p                      : completion pulse and product from the multiplier
//   rsp_valid/rsp_id/rsp_data/rsp_err/rsp_ready : valid/ready response channel
interface mul_req_arbiter_if #(
    parameter int WIDTH = 8
);
    logic                      req0_valid;
    logic signed [WIDTH-1:0]   req0_a;
    logic signed [WIDTH-1:0]   req0_b;
    logic                      req0_ready;

    logic                      req1_valid;
    logic signed [WIDTH-1:0]   req1_a;
    logic signed [WIDTH-1:0]   req1_b;
    logic                      req1_ready;

    logic                      mul_start;
    logic signed [WIDTH-1:0]   mul_a;
    logic signed [WIDTH-1:0]   mul_b;
    logic                      mul_clr;
    logic                      mul_done;
    logic [2*WIDTH-1:0]        mul_p;

    logic                      rsp_valid;
    logic                      rsp_id;
    logic [2*WIDTH-1:0]        rsp_data;
    logic                      rsp_err;
    logic                      rsp_ready;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output mul_start, mul_a, mul_b, mul_clr,
        input  mul_done, mul_p,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  mul_start, mul_a, mul_b, mul_clr,
        output mul_done, mul_p,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/mul_req_arbiter.sv
// Shares one sequential multiplier between two requesters with round-robin
// arbitration and a single operation in flight. A watchdog bounds the wait for
// mul_done; on expiry an error response is returned and mul_clr is pulsed.
// Ports
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : mul_req_arbiter_if.slave (request channels, multiplier command and
//         completion, response channel). All outputs are registered except
//         req0_ready/req1_ready, which are combinational grants in IDLE.
module mul_req_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 31,
    parameter int CNT_W   = 5
) (
    input logic               clk,
    input logic               rst,
    mul_req_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Last watchdog value before the timeout fires (TIMEOUT cycles in WAIT).
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic                    rr_q, rr_d;
    logic                    id_q, id_d;
    logic signed [WIDTH-1:0] a_q, a_d;
    logic signed [WIDTH-1:0] b_q, b_d;
    logic                    start_q, start_d;
    logic                    clr_q, clr_d;
    logic [CNT_W-1:0]        wd_q, wd_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [2*WIDTH-1:0]      rsp_data_q, rsp_data_d;
    logic                    gnt0, gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= 1'b0;
            id_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            start_q     <= 1'b0;
            clr_q       <= 1'b0;
            wd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            start_q     <= start_d;
            clr_q       <= clr_d;
            wd_q        <= wd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        start_d     = 1'b0;
        clr_d       = 1'b0;
        wd_d        = wd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A lone requester always wins; on contention rr_q picks.
                gnt1 = bus.req1_valid && (!bus.req0_valid || rr_q);
                gnt0 = bus.req0_valid && !gnt1;
                if (gnt0 || gnt1) begin
                    id_d    = gnt1;
                    a_d     = gnt1 ? bus.req1_a : bus.req0_a;
                    b_d     = gnt1 ? bus.req1_b : bus.req0_b;
                    rr_d    = !gnt1;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion is checked first so it wins over a same-cycle timeout.
                if (bus.mul_done) begin
                    rsp_data_d  = bus.mul_p;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (wd_q == WD_LAST) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    clr_d       = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.mul_start  = start_q;
    assign bus.mul_a      = a_q;
    assign bus.mul_b      = b_q;
    assign bus.mul_clr    = clr_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule
